// File: rtl/flappy_pkg.sv
// Shared game constants: FSM encoding and bird physics defaults,
// used by the physics, pipe and render stages.
package flappy_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_READY  = 2'd0;
  localparam state_t ST_PLAY   = 2'd1;
  localparam state_t ST_PAUSED = 2'd2;
  localparam state_t ST_DEAD   = 2'd3;

  localparam int DEF_Y_START  = 240;
  localparam int DEF_Y_FLOOR  = 464;  // 480 lines minus a 16-row bird
  localparam int DEF_FLAP_VEL = -8;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_VMAX     = 10;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level. On clear the history
// register takes the live level, so a button held through reset stays quiet.
module edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic in,
  output logic rise
);

  logic prev;

  // Track last-cycle level of the button
  always_ff @(posedge clk) begin
    if (clr) prev <= in;
    else     prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical physics and game FSM. One update per tick: flap or gravity
// sets the new velocity, position integrates it, ceiling clamps, floor kills.
module bird_physics
  import flappy_pkg::*;
#(
  parameter int Y_START  = DEF_Y_START,
  parameter int Y_FLOOR  = DEF_Y_FLOOR,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int VMAX     = DEF_VMAX
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              tick,
  input  logic              flap,
  input  logic              pause,
  input  logic              collide,
  output logic [9:0]        y,
  output logic signed [5:0] vel,
  output logic [1:0]        state,
  output logic              dead
);

  logic              flap_rise, pause_rise;
  logic              flap_pending;
  logic signed [6:0] vel_sum;
  logic signed [5:0] vel_n;
  logic signed [10:0] y_sum;

  edge_detect u_flap_edge (
    .clk  (clk),
    .clr  (clr),
    .in   (flap),
    .rise (flap_rise)
  );

  edge_detect u_pause_edge (
    .clk  (clk),
    .clr  (clr),
    .in   (pause),
    .rise (pause_rise)
  );

  // Candidate next velocity/position for a tick. A flap edge arriving on the
  // tick cycle itself counts as pending so it is never lost.
  always_comb begin
    vel_sum = 7'(vel) + 7'(GRAVITY);
    vel_n   = vel_sum[5:0];
    if (flap_pending || flap_rise)
      vel_n = 6'(FLAP_VEL);
    else if (vel_sum > 7'(VMAX))
      vel_n = 6'(VMAX);
    y_sum = $signed({1'b0, y}) + 11'(vel_n);
  end

  // Game FSM with registered position, velocity and dead flag
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= ST_READY;
      y            <= 10'(Y_START);
      vel          <= '0;
      dead         <= 1'b0;
      flap_pending <= 1'b0;
    end else begin
      case (state)
        ST_READY: begin
          y   <= 10'(Y_START);
          vel <= '0;
          if (flap_rise) begin
            state        <= ST_PLAY;
            flap_pending <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (collide) begin
            state <= ST_DEAD;
            dead  <= 1'b1;
          end else if (pause_rise) begin
            state <= ST_PAUSED;
          end else if (tick) begin
            flap_pending <= 1'b0;
            if (y_sum < 11'sd0) begin
              y   <= '0;
              vel <= '0;
            end else if (y_sum >= 11'(Y_FLOOR)) begin
              y     <= 10'(Y_FLOOR);
              vel   <= '0;
              state <= ST_DEAD;
              dead  <= 1'b1;
            end else begin
              y   <= y_sum[9:0];
              vel <= vel_n;
            end
          end else if (flap_rise) begin
            flap_pending <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (pause_rise) state <= ST_PLAY;
        end
        default: begin
          if (flap_rise) begin
            state        <= ST_READY;
            y            <= 10'(Y_START);
            vel          <= '0;
            dead         <= 1'b0;
            flap_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics: each cycle's stimulus is fed to a
// rule-level game model whose result is queued; a negedge monitor pops and
// compares against the DUT outputs. Directed scenarios add point checks.
module tb_bird_physics;

  logic              clk = 1'b0;
  logic              clr, tick, flap, pause, collide;
  logic [9:0]        y;
  logic signed [5:0] vel;
  logic [1:0]        state;
  logic              dead;

  typedef struct {
    int y;
    int vel;
    int st;
    int dead;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Model state (game rules in plain integers)
  int m_st, m_y, m_vel;
  bit m_pend, m_pf, m_pp;

  bird_physics dut (
    .clk     (clk),
    .clr     (clr),
    .tick    (tick),
    .flap    (flap),
    .pause   (pause),
    .collide (collide),
    .y       (y),
    .vel     (vel),
    .state   (state),
    .dead    (dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the game rules for one clock using the levels sampled at the edge
  task automatic model_step();
    bit fe, pe;
    int v, ny;
    if (clr) begin
      m_st = 0; m_y = 240; m_vel = 0; m_pend = 0;
      m_pf = flap; m_pp = pause;
      return;
    end
    fe = flap && !m_pf;
    pe = pause && !m_pp;
    m_pf = flap;
    m_pp = pause;
    case (m_st)
      0: if (fe) begin m_st = 1; m_pend = 1; end
      1: begin
        if (collide) m_st = 3;
        else if (pe) m_st = 2;
        else if (tick) begin
          if (m_pend || fe) v = -8;
          else v = (m_vel + 1 > 10) ? 10 : m_vel + 1;
          ny = m_y + v;
          m_pend = 0;
          if (ny < 0) begin m_y = 0; m_vel = 0; end
          else if (ny >= 464) begin m_y = 464; m_vel = 0; m_st = 3; end
          else begin m_y = ny; m_vel = v; end
        end else if (fe) m_pend = 1;
      end
      2: if (pe) m_st = 1;
      default: if (fe) begin m_st = 0; m_y = 240; m_vel = 0; m_pend = 0; end
    endcase
  endtask

  // One clock of stimulus; expected outcome queued after the edge
  task automatic cyc(input bit c, input bit t, input bit f, input bit p, input bit k);
    exp_t e;
    clr = c; tick = t; flap = f; pause = p; collide = k;
    @(posedge clk);
    model_step();
    e.y = m_y; e.vel = m_vel; e.st = m_st; e.dead = (m_st == 3) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every registered output cycle against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_y", int'(y), e.y);
      chk("sb_vel", int'(vel), e.vel);
      chk("sb_state", int'(state), e.st);
      chk("sb_dead", int'(dead), e.dead);
    end
  end

  int max_vel;

  initial begin
    clr = 1; tick = 0; flap = 0; pause = 0; collide = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("reset_state", int'(state), 0);
    chk("reset_y", int'(y), 240);
    chk("reset_vel", int'(vel), 0);
    chk("reset_dead", int'(dead), 0);

    // Ticks ignored in READY, then flap starts play
    cyc(0, 1, 0, 0, 0);
    chk("ready_tick_y", int'(y), 240);
    cyc(0, 0, 1, 0, 0);
    chk("start_state", int'(state), 1);
    cyc(0, 1, 0, 0, 0);
    chk("flap_vel", int'(vel), -8);
    chk("flap_y", int'(y), 232);
    cyc(0, 1, 0, 0, 0);
    chk("grav_vel", int'(vel), -7);
    chk("grav_y", int'(y), 225);
    cyc(0, 1, 0, 0, 0);
    chk("grav2_y", int'(y), 219);

    // Climb 8 rows per flap down to y=3, then overshoot the ceiling
    for (int i = 0; i < 27; i++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
    end
    chk("climb_y", int'(y), 3);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("ceil_y", int'(y), 0);
    chk("ceil_vel", int'(vel), 0);
    chk("ceil_state", int'(state), 1);

    // Pause with a same-cycle tick, ticks while paused, unpause
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("pause_state", int'(state), 2);
    chk("pause_y", int'(y), 3);
    chk("pause_vel", int'(vel), 2);
    for (int i = 0; i < 10; i++) cyc(0, 1, i[0], 0, i == 3);
    chk("paused_y", int'(y), 3);
    chk("paused_vel", int'(vel), 2);
    cyc(0, 0, 0, 1, 0);
    chk("unpause_state", int'(state), 1);
    cyc(0, 0, 0, 0, 0);

    // Collide beats tick; flap restarts from READY
    cyc(0, 1, 0, 0, 1);
    chk("coll_state", int'(state), 3);
    chk("coll_y", int'(y), 3);
    chk("coll_dead", int'(dead), 1);
    cyc(0, 0, 0, 1, 0);
    chk("dead_pause_ign", int'(state), 3);
    cyc(0, 0, 1, 0, 0);
    chk("restart_state", int'(state), 0);
    chk("restart_y", int'(y), 240);
    chk("restart_vel", int'(vel), 0);

    // Free fall to the floor, bounded
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    max_vel = -100;
    for (int i = 0; i < 200 && state != 2'd3; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (int'(vel) > max_vel) max_vel = int'(vel);
    end
    chk("fall_vmax", max_vel, 10);
    chk("floor_y", int'(y), 464);
    chk("floor_vel", int'(vel), 0);
    chk("floor_state", int'(state), 3);
    chk("floor_dead", int'(dead), 1);

    // Clear in PLAY with flap held: no spurious restart
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("play_again", int'(state), 1);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
    chk("clr_held_state", int'(state), 0);
    chk("clr_held_y", int'(y), 240);

    // Random play against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 59) == 0);

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
